// File: rtl/line_burst_reader.sv
// line_burst_reader: sequences single-byte writes and line reads into one
// memory_bank and streams read lines out critical-byte-first.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request, bank enable and write enable low
// SETUP  | bank enable high for its single cycle, WE/ADDR/DI presented
// COMMIT | enable low, WE/ADDR/DI held while the RAM samples them
// STREAM | read only: step SELECT over the line, feed the rd channel
module line_burst_reader #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int OFFSET_W = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    input  logic [DATA_W-1:0]   REQ_DATA,
    output logic                WR_DONE,
    output logic                RD_VALID,
    input  logic                RD_READY,
    output logic [DATA_W-1:0]   RD_DATA,
    output logic [OFFSET_W-1:0] RD_OFFSET,
    output logic                RD_LAST,
    output logic                BANK_EN,
    output logic                BANK_WE,
    output logic [ADDR_W-1:0]   BANK_ADDR,
    output logic [DATA_W-1:0]   BANK_DI,
    output logic [OFFSET_W-1:0] BANK_SELECT,
    input  logic [DATA_W-1:0]   BANK_DO
);

    localparam int LINE_BYTES = 1 << OFFSET_W;
    localparam logic [OFFSET_W:0] CNT_FULL = (OFFSET_W + 1)'(LINE_BYTES);
    localparam logic [OFFSET_W:0] CNT_LAST = (OFFSET_W + 1)'(LINE_BYTES - 1);
    localparam logic [OFFSET_W:0] CNT_ONE  = (OFFSET_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        COMMIT = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [OFFSET_W:0]   load_cnt;
    logic [OFFSET_W-1:0] start_off;
    logic                accept;
    logic                stream_load;
    logic                stream_done;

    // REQ_READY is a registered copy of (state == IDLE)
    assign accept      = REQ_VALID && REQ_READY;
    assign stream_load = (state == STREAM) && (load_cnt < CNT_FULL) && (!RD_VALID || RD_READY);
    assign stream_done = (state == STREAM) && RD_VALID && RD_READY && RD_LAST;

    // critical-byte-first walk; wraps naturally at the line boundary
    assign BANK_SELECT = start_off + load_cnt[OFFSET_W-1:0];

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode; BANK_WE still carries the latched request type in COMMIT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = COMMIT;
            COMMIT:  state_next = BANK_WE ? IDLE : STREAM;
            STREAM:  if (stream_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // bank-side registers, request handshake and write completion pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            REQ_READY <= 1'b1;
            WR_DONE   <= 1'b0;
            BANK_EN   <= 1'b0;
            BANK_WE   <= 1'b0;
            BANK_ADDR <= '0;
            BANK_DI   <= '0;
            start_off <= '0;
        end else begin
            REQ_READY <= (state_next == IDLE);
            WR_DONE   <= 1'b0;
            // enable defaults low so it can only ever be high for the SETUP cycle
            BANK_EN   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        BANK_EN   <= 1'b1;
                        BANK_WE   <= REQ_WE;
                        BANK_ADDR <= REQ_ADDR;
                        BANK_DI   <= REQ_DATA;
                        start_off <= REQ_ADDR[OFFSET_W-1:0];
                    end
                end
                COMMIT: begin
                    // RAM sampled WE/ADDR/DI on this edge; WE must drop so DO_BUF drives
                    BANK_WE <= 1'b0;
                    if (BANK_WE) WR_DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // read channel: load a new byte whenever the output register is free or draining
    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_VALID  <= 1'b0;
            RD_DATA   <= '0;
            RD_OFFSET <= '0;
            RD_LAST   <= 1'b0;
            load_cnt  <= '0;
        end else begin
            if (stream_load) begin
                RD_DATA   <= BANK_DO;
                RD_OFFSET <= BANK_SELECT;
                RD_VALID  <= 1'b1;
                RD_LAST   <= (load_cnt == CNT_LAST);
                load_cnt  <= load_cnt + CNT_ONE;
            end else if (RD_VALID && RD_READY) begin
                RD_VALID <= 1'b0;
            end
            if (stream_done) begin
                RD_LAST  <= 1'b0;
                load_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_line_burst_reader.sv
// tb_line_burst_reader: drives line_burst_reader against a behavioural
// memory_bank and scores read bursts from a queue of expected bytes.
module tb_line_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [13:0] req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        wr_done;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [7:0]  rd_data;
    logic [2:0]  rd_offset;
    logic        rd_last;
    logic        bank_en;
    logic        bank_we;
    logic [13:0] bank_addr;
    logic [7:0]  bank_di;
    logic [2:0]  bank_select;
    logic [7:0]  bank_do;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] off;
        logic       last;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ref_mem [0:16383];
    int         n_checks = 0;
    int         n_errors = 0;

    line_burst_reader #(.ADDR_W(14), .DATA_W(8), .OFFSET_W(3)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .WR_DONE(wr_done),
        .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data),
        .RD_OFFSET(rd_offset), .RD_LAST(rd_last),
        .BANK_EN(bank_en), .BANK_WE(bank_we), .BANK_ADDR(bank_addr),
        .BANK_DI(bank_di), .BANK_SELECT(bank_select), .BANK_DO(bank_do)
    );

    always #5 clk = ~clk;

    // memory_bank model: registered enable stage, access one edge after enable
    logic [7:0] mem [0:16383];
    logic [7:0] do_line [0:7];
    logic       en_q;

    always @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= bank_en;
            if (en_q) begin
                if (bank_we) begin
                    mem[bank_addr] <= bank_di;
                end else begin
                    for (int i = 0; i < 8; i++) do_line[i] <= mem[{bank_addr[13:3], 3'(i)}];
                end
            end
        end
    end

    assign bank_do = do_line[bank_select];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // bank enable must never be high on two consecutive cycles
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            if (bank_en) check_val("en_single", 32'(prev_en), 0);
            prev_en = bank_en;
        end
    end

    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) check_val(tag, 32'(req_ready), 1);
    endtask

    task automatic do_write(input logic [13:0] a, input logic [7:0] d);
        wait_ready("wr_req_ready");
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        ref_mem[a] = d;
        check_val("wr_en_e0", 32'(bank_en), 1);
        check_val("wr_we_e0", 32'(bank_we), 1);
        check_val("wr_addr_e0", 32'(bank_addr), 32'(a));
        check_val("wr_di_e0", 32'(bank_di), 32'(d));
        check_val("wr_busy_e0", 32'(req_ready), 0);
        check_val("wr_done_clr", 32'(wr_done), 0);
        @(posedge clk); #1;
        check_val("wr_en_e1", 32'(bank_en), 0);
        check_val("wr_we_e1", 32'(bank_we), 1);
        check_val("wr_addr_e1", 32'(bank_addr), 32'(a));
        check_val("wr_di_e1", 32'(bank_di), 32'(d));
        @(posedge clk); #1;
        check_val("wr_done_e2", 32'(wr_done), 1);
        check_val("wr_ready_e2", 32'(req_ready), 1);
        check_val("wr_we_e2", 32'(bank_we), 0);
    endtask

    task automatic do_read(input logic [13:0] a, input bit bp);
        int         guard, idx, hs, stall, first_idx, last_idx;
        bit         done, prev_stall;
        logic [7:0] prev_data;
        logic [2:0] prev_off, o;
        exp_t       e;
        guard = 0; idx = 0; hs = 0; stall = 0; first_idx = -1; last_idx = -1;
        done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_off = '0;
        for (int k = 0; k < 8; k++) begin
            o = a[2:0] + 3'(k);
            e.data = ref_mem[{a[13:3], o}];
            e.off  = o;
            e.last = (k == 7);
            sb_q.push_back(e);
        end
        wait_ready("rd_req_ready");
        rd_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_data = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("rd_en_e0", 32'(bank_en), 1);
        check_val("rd_we_e0", 32'(bank_we), 0);
        check_val("rd_addr_e0", 32'(bank_addr), 32'(a));
        check_val("rd_wrdone_clr", 32'(wr_done), 0);
        while (!done && guard < 200) begin
            @(negedge clk);
            if (bp && hs == 2 && stall < 3) begin
                rd_ready = 1'b0;
                stall++;
            end else begin
                rd_ready = 1'b1;
            end
            if (prev_stall) begin
                check_val("bp_hold_data", 32'(rd_data), 32'(prev_data));
                check_val("bp_hold_off", 32'(rd_offset), 32'(prev_off));
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_off   = rd_offset;
            if (rd_valid && rd_ready) begin
                if (first_idx < 0) first_idx = idx;
                if (sb_q.size() == 0) begin
                    check_val("rd_extra", sb_q.size(), 1);
                    done = 1'b1;
                end else begin
                    e = sb_q.pop_front();
                    check_val("rd_data", 32'(rd_data), 32'(e.data));
                    check_val("rd_offset", 32'(rd_offset), 32'(e.off));
                    check_val("rd_last", 32'(rd_last), 32'(e.last));
                    hs++;
                    if (rd_last) begin
                        done = 1'b1;
                        last_idx = idx;
                    end
                end
            end
            idx++;
            guard++;
        end
        check_val("rd_done", 32'(done), 1);
        check_val("rd_count", hs, 8);
        check_val("rd_first_lat", first_idx, 3);
        if (!bp) check_val("rd_last_lat", last_idx, 10);
        if (bp) check_val("bp_stalls", stall, 3);
        @(posedge clk); #1;
        check_val("rd_valid_end", 32'(rd_valid), 0);
        check_val("rd_ready_end", 32'(req_ready), 1);
        check_val("sb_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int g;
        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 1);
        check_val("rst_bank_en", 32'(bank_en), 0);
        check_val("rst_bank_we", 32'(bank_we), 0);
        check_val("rst_bank_addr", 32'(bank_addr), 0);
        check_val("rst_bank_di", 32'(bank_di), 0);
        check_val("rst_bank_sel", 32'(bank_select), 0);
        check_val("rst_rd_valid", 32'(rd_valid), 0);
        check_val("rst_rd_data", 32'(rd_data), 0);
        check_val("rst_rd_offset", 32'(rd_offset), 0);
        check_val("rst_rd_last", 32'(rd_last), 0);
        check_val("rst_wr_done", 32'(wr_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // write commit
        do_write(14'h0013, 8'hA5);

        // preload line 0x10 and line 0x20 through the real write path
        for (int i = 0; i < 8; i++) do_write(14'h0010 + 14'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) do_write(14'h0020 + 14'(i), 8'h60 + 8'(i));

        // aligned burst, wrapped burst, backpressured burst
        do_read(14'h0010, 1'b0);
        do_read(14'h0015, 1'b0);
        do_read(14'h0013, 1'b1);

        // reset during a write's COMMIT: write aborted, byte keeps old value
        wait_ready("abort_req_ready");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0015; req_data = 8'hEE;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_we", 32'(bank_we), 0);
        check_val("abort_en", 32'(bank_en), 0);
        check_val("abort_ready", 32'(req_ready), 1);
        check_val("abort_wr_done", 32'(wr_done), 0);
        @(negedge clk);
        rst = 1'b0;
        do_read(14'h0010, 1'b0);

        // reset during STREAM: partial burst discarded
        wait_ready("srst_req_ready");
        rd_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g = 0;
        @(negedge clk);
        while (!rd_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!rd_valid) check_val("srst_valid_seen", 32'(rd_valid), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("srst_rd_valid", 32'(rd_valid), 0);
        check_val("srst_req_ready", 32'(req_ready), 1);
        check_val("srst_rd_last", 32'(rd_last), 0);
        check_val("srst_bank_sel", 32'(bank_select), 0);
        check_val("srst_bank_en", 32'(bank_en), 0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back write then read of the same line
        do_write(14'h0022, 8'h5A);
        do_read(14'h0020, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
